cdb_arbiter: RTL



---
 rtl/cdb_arbiter_pkg.sv | 15 +
 rtl/cdb_arbiter_if.sv | 41 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/cdb_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbitration stage: the entry carried from a source slot onto the bus.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_XLEN = 32;
  localparam int unsigned REG_W    = 6;

  typedef struct packed {
    logic [CDB_XLEN-1:0] result;
    logic [CDB_XLEN-1:0] address;
    logic [CDB_XLEN-1:0] jmp_address;
    logic [REG_W-1:0]    arn;
    logic [REG_W-1:0]    rrn;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source-side and bus-side signals of the CDB arbiter; the arbiter uses the slave modport.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned XLEN  = 32
);

  logic                            flush;
  logic [N_SRC-1:0]                src_valid;
  logic [N_SRC-1:0]                src_ready;
  logic [N_SRC-1:0][XLEN-1:0]      src_result;
  logic [N_SRC-1:0][XLEN-1:0]      src_address;
  logic [N_SRC-1:0][XLEN-1:0]      src_jmp_address;
  logic [N_SRC-1:0][REG_W-1:0]     src_arn;
  logic [N_SRC-1:0][REG_W-1:0]     src_rrn;

  logic                            cdb_valid;
  logic                            cdb_ready;
  logic [XLEN-1:0]                 cdb_result;
  logic [XLEN-1:0]                 cdb_address;
  logic [XLEN-1:0]                 cdb_jmp_address;
  logic [REG_W-1:0]                cdb_arn;
  logic [REG_W-1:0]                cdb_rrn;
  logic [N_SRC-1:0]                cdb_select;

  modport master (
    output flush, src_valid, src_result, src_address, src_jmp_address, src_arn, src_rrn,
    output cdb_ready,
    input  src_ready,
    input  cdb_valid, cdb_result, cdb_address, cdb_jmp_address, cdb_arn, cdb_rrn, cdb_select
  );

  modport slave (
    input  flush, src_valid, src_result, src_address, src_jmp_address, src_arn, src_rrn,
    input  cdb_ready,
    output src_ready,
    output cdb_valid, cdb_result, cdb_address, cdb_jmp_address, cdb_arn, cdb_rrn, cdb_select
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    // Offset N lands back on i_ptr itself, so the last winner is considered last.
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % N);
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-source one-entry slots, round-robin grant and a registered, back-pressurable bus stage.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic         clk,
  input logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  if (XLEN != CDB_XLEN) begin : g_xlen_chk
    $error("cdb_arbiter: XLEN must equal the width fixed in cdb_entry_t");
  end

  logic [N_SRC-1:0] r_full;
  cdb_entry_t       r_slot [N_SRC];
  cdb_entry_t       r_out;
  logic             r_cdb_valid;
  logic [N_SRC-1:0] r_select;
  logic [PTR_W-1:0] r_rr_ptr;

  logic             w_out_free;
  logic             w_arb_en;
  logic [N_SRC-1:0] w_gnt;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [N_SRC-1:0] w_src_ready;
  cdb_entry_t       w_src_entry [N_SRC];

  assign w_out_free = !r_cdb_valid || bus.cdb_ready;
  assign w_arb_en   = w_out_free && !bus.flush;

  rr_arbiter #(
    .N    (N_SRC),
    .PTR_W(PTR_W)
  ) u_rr_arbiter (
    .i_req    (r_full),
    .i_ptr    (r_rr_ptr),
    .i_en     (w_arb_en),
    .o_gnt    (w_gnt),
    .o_gnt_idx(w_gnt_idx)
  );

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    // A slot being granted this cycle may take a new result in the same cycle.
    assign w_src_ready[i] = !reset && !bus.flush && (!r_full[i] || w_gnt[i]);
    assign w_src_entry[i] = '{result:      bus.src_result[i],
                              address:     bus.src_address[i],
                              jmp_address: bus.src_jmp_address[i],
                              arn:         bus.src_arn[i],
                              rrn:         bus.src_rrn[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= '0;
      for (int i = 0; i < N_SRC; i++) r_slot[i] <= '0;
    end else if (bus.flush) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (bus.src_valid[i] && w_src_ready[i]) begin
          r_full[i] <= 1'b1;
          r_slot[i] <= w_src_entry[i];
        end else if (w_gnt[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cdb_valid <= 1'b0;
      r_out       <= '0;
      r_select    <= '0;
      r_rr_ptr    <= PTR_W'(N_SRC - 1);
    end else if (bus.flush) begin
      r_cdb_valid <= 1'b0;
    end else if (w_out_free) begin
      r_cdb_valid <= |w_gnt;
      if (|w_gnt) begin
        r_out    <= r_slot[w_gnt_idx];
        r_select <= w_gnt;
        r_rr_ptr <= w_gnt_idx;
      end
    end
  end

  assign bus.src_ready       = w_src_ready;
  assign bus.cdb_valid       = r_cdb_valid;
  assign bus.cdb_result      = r_out.result;
  assign bus.cdb_address     = r_out.address;
  assign bus.cdb_jmp_address = r_out.jmp_address;
  assign bus.cdb_arn         = r_out.arn;
  assign bus.cdb_rrn         = r_out.rrn;
  assign bus.cdb_select      = r_select;

endmodule
